// File: rtl/des_byte_loader_if.sv
// Byte-stream handshake and DES core load bundle for des_byte_loader.
interface des_byte_loader_if;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_is_key;
    logic        in_ready;
    logic        load;
    logic [63:0] data_in;
    logic [63:0] key_in;
    logic        key_ok;
    logic        drop;
    logic        busy;

    modport slave (
        input  in_byte, in_valid, in_is_key,
        output in_ready, load, data_in, key_in, key_ok, drop, busy
    );

    modport master (
        output in_byte, in_valid, in_is_key,
        input  in_ready, load, data_in, key_in, key_ok, drop, busy
    );
endinterface

// File: rtl/des_byte_loader.sv
// Assembles MSB-first byte stream into DES key/data words and paces
// core loads so each result is out before the next block is loaded.
module des_byte_loader #(
    parameter int CORE_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    des_byte_loader_if.slave  bus
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LOAD    = 2'd1,
        WAIT    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [55:0] r_sr;
    logic [2:0]  r_cnt;
    logic        r_is_key;
    logic [63:0] r_key;
    logic [63:0] r_data;
    logic        r_key_ok;
    logic        r_drop;
    logic [7:0]  r_wcnt;

    logic        w_accept;
    logic        w_last;
    logic [63:0] w_word;

    assign w_accept = bus.in_valid && (r_state == COLLECT);
    assign w_last   = w_accept && (r_cnt == 3'd7);
    assign w_word   = {r_sr, bus.in_byte};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= COLLECT;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            COLLECT: if (w_last && !r_is_key && r_key_ok) w_next = LOAD;
            LOAD:    w_next = WAIT;
            WAIT:    if (r_wcnt == 8'd0) w_next = COLLECT;
            default: w_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr     <= '0;
            r_cnt    <= '0;
            r_is_key <= 1'b0;
            r_key    <= '0;
            r_data   <= '0;
            r_key_ok <= 1'b0;
            r_drop   <= 1'b0;
            r_wcnt   <= '0;
        end else begin
            r_drop <= 1'b0;
            if (w_accept) begin
                r_sr  <= w_word[55:0];
                r_cnt <= r_cnt + 3'd1;
                // Word kind is fixed by the first byte only
                if (r_cnt == 3'd0) r_is_key <= bus.in_is_key;
            end
            if (w_last) begin
                if (r_is_key) begin
                    r_key    <= w_word;
                    r_key_ok <= 1'b1;
                end else if (r_key_ok) begin
                    r_data <= w_word;
                end else begin
                    r_drop <= 1'b1;
                end
            end
            if (r_state == LOAD)      r_wcnt <= 8'(CORE_LATENCY - 1);
            else if (r_state == WAIT) r_wcnt <= r_wcnt - 8'd1;
        end
    end

    assign bus.in_ready = (r_state == COLLECT);
    assign bus.load     = (r_state == LOAD);
    assign bus.busy     = (r_state != COLLECT);
    assign bus.data_in  = r_data;
    assign bus.key_in   = r_key;
    assign bus.key_ok   = r_key_ok;
    assign bus.drop     = r_drop;

endmodule

// File: tb/tb_des_byte_loader.sv
// Scoreboard bench for des_byte_loader: two instances (latency 2 and 5)
// share one stimulus driver selected by sel.
module tb_des_byte_loader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [7:0] d_byte = '0;
    logic       d_valid = 1'b0;
    logic       d_key = 1'b0;
    logic       sel = 1'b0;

    des_byte_loader_if ifa ();
    des_byte_loader_if ifb ();

    assign ifa.in_byte   = d_byte;
    assign ifa.in_is_key = d_key;
    assign ifa.in_valid  = d_valid && !sel;
    assign ifb.in_byte   = d_byte;
    assign ifb.in_is_key = d_key;
    assign ifb.in_valid  = d_valid && sel;

    des_byte_loader #(.CORE_LATENCY(2)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    des_byte_loader #(.CORE_LATENCY(5)) u_b (.clk(clk), .reset(reset), .bus(ifb));

    logic        m_ready, m_load, m_busy, m_drop, m_key_ok;
    logic [63:0] m_data, m_key;
    assign m_ready  = sel ? ifb.in_ready : ifa.in_ready;
    assign m_load   = sel ? ifb.load     : ifa.load;
    assign m_busy   = sel ? ifb.busy     : ifa.busy;
    assign m_drop   = sel ? ifb.drop     : ifa.drop;
    assign m_key_ok = sel ? ifb.key_ok   : ifa.key_ok;
    assign m_data   = sel ? ifb.data_in  : ifa.data_in;
    assign m_key    = sel ? ifb.key_in   : ifa.key_in;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        is_load;
        logic [63:0] data;
        logic [63:0] key;
    } ev_t;
    ev_t exp_q[$];
    int  load_cyc[$];
    int  n_load = 0;
    int  n_drop = 0;

    // Reference model: byte-level view of the stream
    int          mcnt = 0;
    logic        mkind = 1'b0;
    logic        mkey_ok = 1'b0;
    logic [63:0] mword = '0;
    logic [63:0] mkey = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input logic k);
        if (mcnt == 0) mkind = k;
        mword = {mword[55:0], b};
        mcnt++;
        if (mcnt == 8) begin
            mcnt = 0;
            if (mkind) begin
                mkey = mword;
                mkey_ok = 1'b1;
            end else if (mkey_ok) begin
                exp_q.push_back('{is_load: 1'b1, data: mword, key: mkey});
            end else begin
                exp_q.push_back('{is_load: 1'b0, data: mword, key: mkey});
            end
        end
    endtask

    task automatic model_clear();
        mcnt = 0;
        mkey_ok = 1'b0;
        mkey = '0;
        mword = '0;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic k);
        int guard = 0;
        d_byte = b;
        d_key = k;
        d_valid = 1'b1;
        while (!m_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (!m_ready) begin
            chk("send_timeout", 64'd1, 64'd0);
        end else begin
            model_accept(b, k);
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        d_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [63:0] w, input logic kind,
                             input bit toggle, input int gapmax);
        logic k;
        for (int i = 0; i < 8; i++) begin
            k = (toggle && i > 0) ? 1'($urandom) : kind;
            send_byte(w[63 - 8*i -: 8], k);
            if (gapmax > 0 && $urandom_range(0, 2) == 0)
                idle($urandom_range(1, gapmax));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ctl"}, {59'd0, m_ready, m_load, m_busy, m_drop, m_key_ok},
            64'b10000);
        chk({tag, "_data"}, m_data, 64'd0);
        chk({tag, "_key"}, m_key, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        d_valid = 1'b0;
        #1;
        check_reset_vals(tag);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops expectations on load/drop and times the busy window
    bit          win = 0;
    int          low = 0;
    bit          unstable = 0;
    logic [63:0] cap_d, cap_k;
    ev_t         e;

    always @(negedge clk) begin
        if (reset) begin
            win = 0;
        end else begin
            if (m_drop) begin
                n_drop++;
                if (exp_q.size() == 0) begin
                    chk("drop_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("drop_kind", {63'd0, e.is_load}, 64'd0);
                end
            end
            if (m_load) begin
                n_load++;
                load_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("load_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_kind", {63'd0, e.is_load}, 64'd1);
                    chk("load_data", m_data, e.data);
                    chk("load_key", m_key, e.key);
                end
                win = 1;
                low = 0;
                unstable = 0;
                cap_d = m_data;
                cap_k = m_key;
            end
            if (win) begin
                if (!m_ready) begin
                    low++;
                    if (m_data !== cap_d || m_key !== cap_k) unstable = 1;
                    if (!m_busy) unstable = 1;
                end else begin
                    chk("ready_low", 64'(low), 64'(sel ? 6 : 3));
                    chk("stable", {63'd0, unstable}, 64'd0);
                    win = 0;
                end
            end
        end
    end

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] D1 = 64'h0123456789ABCDEF;

    initial begin
        int nl, nd;
        logic [63:0] w;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_init");
        reset = 1'b0;
        @(negedge clk);

        // Key then data
        send_word(K1, 1'b1, 0, 0);
        send_word(D1, 1'b0, 0, 0);
        idle(6);
        chk("t1_key", m_key, K1);
        chk("t1_data", m_data, D1);
        chk("t1_loads", 64'(n_load), 64'd1);
        chk("t1_key_ok", {63'd0, m_key_ok}, 64'd1);

        // Data without a key is dropped
        do_reset("reset_t2");
        nl = n_load;
        nd = n_drop;
        send_word(64'hA5A5_0F0F_1234_5678, 1'b0, 0, 0);
        idle(4);
        chk("t2_drop", 64'(n_drop - nd), 64'd1);
        chk("t2_noload", 64'(n_load - nl), 64'd0);
        chk("t2_data", m_data, 64'd0);
        chk("t2_ready", {63'd0, m_ready}, 64'd1);

        // Back-pressure: valid held across two data words
        do_reset("reset_t3");
        nl = n_load;
        w = {$urandom, $urandom};
        send_word(K1, 1'b1, 0, 0);
        send_word(D1, 1'b0, 0, 0);
        send_word(w, 1'b0, 0, 0);
        idle(6);
        chk("t3_loads", 64'(n_load - nl), 64'd2);
        if (load_cyc.size() >= 2)
            chk("t3_spacing", 64'(load_cyc[$] - load_cyc[$-1]), 64'd11);
        chk("t3_data2", m_data, w);

        // Gaps and in_is_key toggling mid-word
        w = {$urandom, $urandom};
        send_word(w, 1'b0, 1, 3);
        idle(6);
        chk("t4_data", m_data, w);

        // Reset mid-word, then a fresh key+data
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        do_reset("reset_t5");
        nl = n_load;
        send_word(64'hFEDC_BA98_7654_3210, 1'b1, 0, 0);
        send_word(64'h0011_2233_4455_6677, 1'b0, 0, 0);
        idle(6);
        chk("t5_key", m_key, 64'hFEDC_BA98_7654_3210);
        chk("t5_data", m_data, 64'h0011_2233_4455_6677);
        chk("t5_loads", 64'(n_load - nl), 64'd1);

        // Random traffic against the scoreboard
        for (int i = 0; i < 30; i++) begin
            w = {$urandom, $urandom};
            send_word(w, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, 2);
        end
        idle(8);

        // Latency 5 instance
        sel = 1'b1;
        do_reset("reset_t6");
        nl = n_load;
        send_word(K1, 1'b1, 0, 0);
        send_word(D1, 1'b0, 0, 0);
        idle(10);
        chk("t6_loads", 64'(n_load - nl), 64'd1);
        chk("t6_data", m_data, D1);
        for (int i = 0; i < 12; i++) begin
            w = {$urandom, $urandom};
            send_word(w, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, 2);
        end
        idle(10);

        chk("drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/des_byte_loader.md
# des_byte_loader

Upstream feeder for the DES core. Accepts a byte-serial stream over a valid/ready handshake and assembles 64-bit key and data words MSB-first. On each completed data word it presents `data_in`/`key_in` to the core with a single-cycle `load` pulse. It then holds off further input for the core's fixed latency, so the core's `data_out` for that block is produced before the next block is loaded.

## Interface
- `CORE_LATENCY`, default 2: cycles from the `load` pulse to the core's `data_out` update; legal range 1..255.
- `clk  in  1`: single clock; all logic on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `in_byte  in  8`: input byte; the first byte of a word is the MSB.
- `in_valid  in  1`: `in_byte` is valid.
- `in_is_key  in  1`: word kind; sampled only on the first byte of a word (1 = key, 0 = data).
- `in_ready  out  1`: block accepts a byte this cycle.
- `load  out  1`: one-cycle pulse to the DES core.
- `data_in  out  64`: data block to the core.
- `key_in  out  64`: key to the core.
- `key_ok  out  1`: a complete key has been received since reset.
- `drop  out  1`: one-cycle pulse when a data word is discarded because no key has been received.
- `busy  out  1`: high while in LOAD or WAIT.

## Operation
- Transfer: a byte is accepted on a rising edge where `in_valid && in_ready`.
- Assembly: shift register `sr <= {sr[55:0], in_byte}`; 3-bit byte counter `cnt`.
- Word kind is latched from `in_is_key` when `cnt==0`. Changes of `in_is_key` mid-word are ignored.

State machine (COLLECT, LOAD, WAIT):
- COLLECT: `in_ready=1`. On accept, `cnt++`. On the 8th byte (`cnt==7`), with `w = {sr[55:0], in_byte}`, `cnt` returns to 0 and:
  - key word: `key_in <= w`, `key_ok <= 1`; stay in COLLECT.
  - data word with `key_ok=1`: `data_in <= w`; go to LOAD.
  - data word with `key_ok=0`: `drop` pulses the next cycle; `data_in` is unchanged; stay in COLLECT.
- LOAD: `load=1`, `in_ready=0`; go to WAIT with the wait counter set to `CORE_LATENCY-1`.
- WAIT: `in_ready=0`; counter decrements; when the counter is 0, return to COLLECT.
- `key_in` and `data_in` change only in COLLECT, so both are stable during LOAD and WAIT.
- A key word may arrive between any two data words. The new key applies to all subsequent loads and the old key is overwritten.
- `in_ready`, `load` and `busy` are decoded from the state register. `drop` is registered.

## Timing
Reset values:
- state = COLLECT, so `in_ready=1`.
- `load=0`, `busy=0`, `drop=0`, `key_ok=0`.
- `data_in=0`, `key_in=0`, `cnt=0`, `sr=0`.

Throughput: one byte per cycle while in COLLECT.

Data-word timing, with the 8th data byte accepted at edge E:
- `data_in` is valid from E.
- `load=1` for exactly the cycle after E.
- WAIT lasts `CORE_LATENCY` cycles.
- `in_ready` is high again `CORE_LATENCY+1` cycles after E.
- With the default, the core's result appears while `in_ready` is still low.
- Minimum period per block is 8 + 1 + `CORE_LATENCY` cycles.

Boundary conditions:
- `in_valid` low mid-word: the partial word is held indefinitely with no timeout.
- `in_valid` high while `in_ready=0`: no byte is consumed; the source must hold the byte.
- Reset at any point, including mid-word, LOAD or WAIT: all state returns to the reset values immediately. The partial word is lost, `key_ok` clears and any pending `load` is cancelled.
- Key word completing while `key_ok=1`: `key_in` is replaced and no `load` occurs.

## Test plan
1. Key then data: reset; key bytes 13 34 57 79 9B BC DF F1; data bytes 01 23 45 67 89 AB CD EF → `key_in=133457799BBCDFF1`, `data_in=0123456789ABCDEF`, exactly one `load` pulse in the cycle after the 16th byte; `in_ready` low 3 cycles.
2. No key: after reset, 8 data bytes → `drop` pulses once, `load` never asserts, `data_in` stays 0, `in_ready` stays 1.
3. Back-pressure: hold `in_valid=1` continuously across two data words → 2 `load` pulses 11 cycles apart (`CORE_LATENCY=2`); no byte lost; the second `data_in` equals the second word.
4. Gaps and mid-word kind change: insert `in_valid=0` gaps and toggle `in_is_key` after byte 0 of a data word → assembly is unaffected and the word is still treated as data.
5. Reset mid-word: assert `reset` after 5 data bytes → all outputs return to the reset values. A subsequent key+data sequence loads correctly with 8 fresh bytes each.
6. Parameter: `CORE_LATENCY=5` → `in_ready` low for 6 cycles after the 8th byte (LOAD plus 5 WAIT cycles); `key_in`/`data_in` stable throughout.
